// File: rtl/joypad_pkg.sv
// Shared types and constants for the joypad serial arbiter and its shifter.
package joypad_pkg;

  localparam int unsigned SHIFT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic [2:0] PAD0 = 3'd0;
  localparam logic [2:0] PAD1 = 3'd1;
  localparam logic [2:0] PAD2 = 3'd2;
  localparam logic [2:0] PAD3 = 3'd3;
  localparam logic [2:0] KBD  = 3'd4;
  localparam logic [2:0] NONE = 3'd7;

  function automatic logic [2:0] pad_owner(input logic [1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/famicom_shifter.sv
// Famicom-style parallel-load, serial-out shift register with bit counter.
module famicom_shifter
  import joypad_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [SHIFT_W-1:0] load_byte,
  input  logic               shift,
  output logic               data
);

  shift_state_t       state_q;
  logic [SHIFT_W-1:0] shreg_q;
  logic [3:0]         cnt_q;

  // Load has priority over shift; idle/done states keep shifting 1s in.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      shreg_q <= '1;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      shreg_q <= load_byte;
      cnt_q   <= 4'(SHIFT_W);
    end else if (shift) begin
      shreg_q <= {1'b1, shreg_q[SHIFT_W-1:1]};
      case (state_q)
        SHIFT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign data = shreg_q[0];

endmodule

// File: rtl/joypad_serial_arbiter.sv
// Arbitrates four pads and a keyboard byte onto one Famicom serial port.
module joypad_serial_arbiter
  import joypad_pkg::*;
#(
  parameter int unsigned KB_HOLD = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       famicom_latch,
  input  logic       famicom_pulse,
  input  logic [7:0] joystick_0,
  input  logic [7:0] joystick_1,
  input  logic [7:0] joystick_2,
  input  logic [7:0] joystick_3,
  input  logic [7:0] kb_code,
  input  logic       kb_strobe,
  output logic       famicom_data,
  output logic [2:0] owner,
  output logic       kb_pending
);

  localparam logic [3:0] KB_HOLD_L = 4'(KB_HOLD);

  logic       latch_q, pulse_q;
  logic       latch_rise, pulse_rise;
  logic       lock_valid_q, lock_valid_d;
  logic [1:0] lock_idx_q, lock_idx_d;
  logic [7:0] kb_code_q, kb_code_d;
  logic [3:0] kb_hold_q, kb_hold_d;
  logic       kb_pending_q, kb_pending_d;
  logic [2:0] owner_q, owner_d;
  logic [7:0] sel_byte;
  logic [7:0] load_byte;
  logic [3:0] hold_dec;
  logic       lock_live;
  logic       any_pad;
  logic [1:0] low_idx;

  logic [7:0] pad [4];
  logic [3:0] pad_nz;

  assign pad[0] = joystick_0;
  assign pad[1] = joystick_1;
  assign pad[2] = joystick_2;
  assign pad[3] = joystick_3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pad_nz
    assign pad_nz[gi] = |pad[gi];
  end

  assign latch_rise = famicom_latch & ~latch_q;
  assign pulse_rise = famicom_pulse & ~pulse_q;
  assign lock_live  = lock_valid_q & pad_nz[lock_idx_q];
  assign any_pad    = |pad_nz;
  assign hold_dec   = kb_hold_q - 4'd1;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pad_nz[i]) begin
        low_idx = 2'(i);
      end
    end
  end

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    kb_code_d    = kb_code_q;
    kb_hold_d    = kb_hold_q;
    kb_pending_d = kb_pending_q;
    owner_d      = owner_q;
    sel_byte     = 8'h00;

    if (latch_rise) begin
      if (kb_pending_q) begin
        // Keyboard pre-empts the pad but a held pad keeps its lock.
        owner_d      = KBD;
        sel_byte     = kb_code_q;
        kb_hold_d    = hold_dec;
        kb_pending_d = (hold_dec != 4'd0);
        lock_valid_d = lock_live;
      end else if (lock_live) begin
        owner_d  = pad_owner(lock_idx_q);
        sel_byte = pad[lock_idx_q];
      end else if (any_pad) begin
        owner_d      = pad_owner(low_idx);
        sel_byte     = pad[low_idx];
        lock_valid_d = 1'b1;
        lock_idx_d   = low_idx;
      end else begin
        owner_d      = NONE;
        lock_valid_d = 1'b0;
      end
    end

    // A strobe coinciding with a latch is only presented on the following latch.
    if (kb_strobe) begin
      kb_code_d    = kb_code;
      kb_hold_d    = KB_HOLD_L;
      kb_pending_d = 1'b1;
    end
  end

  assign load_byte = ~sel_byte;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      latch_q      <= 1'b0;
      pulse_q      <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= 2'd0;
      kb_code_q    <= 8'h00;
      kb_hold_q    <= 4'd0;
      kb_pending_q <= 1'b0;
      owner_q      <= NONE;
    end else begin
      latch_q      <= famicom_latch;
      pulse_q      <= famicom_pulse;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      kb_code_q    <= kb_code_d;
      kb_hold_q    <= kb_hold_d;
      kb_pending_q <= kb_pending_d;
      owner_q      <= owner_d;
    end
  end

  famicom_shifter u_shifter (
    .clk       (clk_sys),
    .srst      (reset),
    .load      (latch_rise),
    .load_byte (load_byte),
    .shift     (pulse_rise & ~latch_rise),
    .data      (famicom_data)
  );

  assign owner      = owner_q;
  assign kb_pending = kb_pending_q;

endmodule

// File: tb/tb_joypad_serial_arbiter.sv
// Directed bench for joypad_serial_arbiter with hand-computed expectations.
module tb_joypad_serial_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       famicom_latch = 1'b0;
  logic       famicom_pulse = 1'b0;
  logic [7:0] joystick_0 = 8'h00;
  logic [7:0] joystick_1 = 8'h00;
  logic [7:0] joystick_2 = 8'h00;
  logic [7:0] joystick_3 = 8'h00;
  logic [7:0] kb_code = 8'h00;
  logic       kb_strobe = 1'b0;
  logic       famicom_data;
  logic [2:0] owner;
  logic       kb_pending;

  int tests_run = 0;
  int tests_failed = 0;

  joypad_serial_arbiter #(.KB_HOLD(2)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .joystick_0    (joystick_0),
    .joystick_1    (joystick_1),
    .joystick_2    (joystick_2),
    .joystick_3    (joystick_3),
    .kb_code       (kb_code),
    .kb_strobe     (kb_strobe),
    .famicom_data  (famicom_data),
    .owner         (owner),
    .kb_pending    (kb_pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_latch();
    famicom_latch = 1'b1;
    tick();
    famicom_latch = 1'b0;
    tick();
  endtask

  task automatic do_pulse();
    famicom_pulse = 1'b1;
    tick();
    famicom_pulse = 1'b0;
    tick();
  endtask

  // exp_bits holds the expected wire sequence, bit0 first, for a full 8-bit read.
  task automatic read_byte(input string tag, input logic [7:0] exp_bits);
    check({tag, "_b0"}, {7'd0, famicom_data}, {7'd0, exp_bits[0]});
    for (int i = 1; i < 8; i++) begin
      do_pulse();
      check($sformatf("%s_b%0d", tag, i), {7'd0, famicom_data}, {7'd0, exp_bits[i]});
    end
    do_pulse();
    check({tag, "_tail"}, {7'd0, famicom_data}, 8'h01);
  endtask

  initial begin
    tick();
    tick();
    check("rst_data", {7'd0, famicom_data}, 8'h01);
    check("rst_owner", {5'd0, owner}, 8'h07);
    check("rst_kbp", {7'd0, kb_pending}, 8'h00);
    reset = 1'b0;
    tick();

    // Pad 2 alone: 0x05 -> wire 0,1,0,1,1,1,1,1
    joystick_2 = 8'h05;
    do_latch();
    check("p2_owner", {5'd0, owner}, 8'h02);
    read_byte("p2", 8'b1111_1010);

    // Lock holds pad1 even after pad0 is pressed
    joystick_2 = 8'h00;
    joystick_1 = 8'h01;
    do_latch();
    check("lock_first", {5'd0, owner}, 8'h01);
    joystick_0 = 8'h80;
    do_latch();
    check("lock_hold", {5'd0, owner}, 8'h01);
    joystick_1 = 8'h00;
    do_latch();
    check("lock_release", {5'd0, owner}, 8'h00);
    check("lock_rel_data", {7'd0, famicom_data}, 8'h01);

    // Keyboard 0x41 for two latches with pad0 held
    joystick_0 = 8'h01;
    kb_code = 8'h41;
    kb_strobe = 1'b1;
    tick();
    kb_strobe = 1'b0;
    tick();
    check("kb_pend", {7'd0, kb_pending}, 8'h01);
    do_latch();
    check("kb1_owner", {5'd0, owner}, 8'h04);
    read_byte("kb1", 8'b1011_1110);
    do_latch();
    check("kb2_owner", {5'd0, owner}, 8'h04);
    check("kb2_pend", {7'd0, kb_pending}, 8'h00);
    read_byte("kb2", 8'b1011_1110);
    do_latch();
    check("kb3_owner", {5'd0, owner}, 8'h00);
    check("kb3_pend", {7'd0, kb_pending}, 8'h00);
    check("kb3_data", {7'd0, famicom_data}, 8'h00);

    // Re-latch after 3 pulses restarts from bit0 of the new byte
    joystick_0 = 8'h36;
    do_latch();
    do_pulse();
    do_pulse();
    do_pulse();
    check("mid_bit3", {7'd0, famicom_data}, 8'h01);
    joystick_0 = 8'h0F;
    do_latch();
    check("relatch_owner", {5'd0, owner}, 8'h00);
    read_byte("relatch", 8'b1111_0000);

    // Latch and pulse on the same cycle: load wins, no shift
    joystick_0 = 8'h02;
    famicom_latch = 1'b1;
    famicom_pulse = 1'b1;
    tick();
    check("coinc_b0", {7'd0, famicom_data}, 8'h01);
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    tick();
    do_pulse();
    check("coinc_b1", {7'd0, famicom_data}, 8'h00);

    // Strobe on the latch cycle is deferred to the next latch
    kb_code = 8'h41;
    kb_strobe = 1'b1;
    famicom_latch = 1'b1;
    tick();
    kb_strobe = 1'b0;
    famicom_latch = 1'b0;
    tick();
    check("defer_owner", {5'd0, owner}, 8'h00);
    check("defer_pend", {7'd0, kb_pending}, 8'h01);
    check("defer_data", {7'd0, famicom_data}, 8'h01);
    do_latch();
    check("defer_kb1", {5'd0, owner}, 8'h04);
    check("defer_kb1_data", {7'd0, famicom_data}, 8'h00);
    do_latch();
    check("defer_kb2", {5'd0, owner}, 8'h04);
    do_latch();
    check("defer_pad", {5'd0, owner}, 8'h00);

    // Reset mid-shift aborts and leaves the line idle
    joystick_0 = 8'h05;
    do_latch();
    for (int i = 0; i < 4; i++) do_pulse();
    reset = 1'b1;
    tick();
    check("mrst_data", {7'd0, famicom_data}, 8'h01);
    check("mrst_owner", {5'd0, owner}, 8'h07);
    check("mrst_pend", {7'd0, kb_pending}, 8'h00);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      do_pulse();
      check($sformatf("idle_p%0d", i), {7'd0, famicom_data}, 8'h01);
    end
    check("idle_owner", {5'd0, owner}, 8'h07);

    // Latch already high when reset releases is seen as an edge
    reset = 1'b1;
    famicom_latch = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rel_owner", {5'd0, owner}, 8'h00);
    check("rel_data", {7'd0, famicom_data}, 8'h00);
    famicom_latch = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/joypad_serial_arbiter.md
JOYPAD_SERIAL_ARBITER -- requirements
Module: joypad_serial_arbiter

Interface
REQ-001 The block SHALL have parameter KB_HOLD, default 2, the number of latch events a keyboard byte is presented for (range 1-15).
REQ-002 The block SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port famicom_latch, input, 1, the latch strobe from the Gigatron; active high.
REQ-005 The block SHALL have port famicom_pulse, input, 1, the shift clock from the Gigatron.
REQ-006 The block SHALL have ports joystick_0..joystick_3, input, 8 each, pad buttons already in wire order (bit0 shifted first); 1 = pressed.
REQ-007 The block SHALL have port kb_code, input, 8, keyboard byte in wire order; 1 = asserted bit.
REQ-008 The block SHALL have port kb_strobe, input, 1, a one-cycle pulse that kb_code is valid.
REQ-009 The block SHALL have port famicom_data, output, 1, serial data to the Gigatron; active-low (0 = pressed).
REQ-010 The block SHALL have port owner, output, 3, the current source: 0-3 = pad N, 4 = keyboard, 7 = none.
REQ-011 The block SHALL have port kb_pending, output, 1, high while a keyboard byte awaits or is being presented.

Function
REQ-012 The block SHALL edge-detect latch and pulse against a one-cycle registered copy of each; no further synchronisation.
REQ-013 The arbitration decision SHALL be taken only on the cycle a latch rising edge is detected.
REQ-014 Priority SHALL be: keyboard if pending, then the locked pad, then the lowest-numbered pad with any bit set, then none.
REQ-015 A pad becomes locked when it wins, and SHALL stay locked until a latch edge samples its byte as zero.
REQ-016 On kb_strobe, kb_code SHALL be captured and the hold count set to KB_HOLD; a strobe while pending overwrites the code and reloads the count.
REQ-017 Each latch edge that selects the keyboard SHALL decrement the hold count; kb_pending clears when the count reaches 0.
REQ-018 A strobe on the same cycle as a latch edge SHALL be captured, and SHALL NOT be presented until the next latch edge.
REQ-019 The loaded shift byte SHALL be the bitwise inverse of the selected source byte; "none" loads 0xFF.
REQ-020 The shifter states SHALL be IDLE, then SHIFT (8 bits remaining, counter 8 down to 1), then DONE.
REQ-021 In every state, a latch edge SHALL load the shifter and enter SHIFT with a count of 8.
REQ-022 In SHIFT, each pulse rising edge SHALL shift right, fill the top bit with 1, and decrement the count; it enters DONE at count 0.
REQ-023 In DONE and IDLE, pulse edges SHALL shift in 1s so that famicom_data reads 1.
REQ-024 If a latch edge and a pulse edge occur on the same cycle, the latch SHALL win and the pulse SHALL be ignored.
REQ-025 famicom_data SHALL equal the shifter bit 0; a new value is visible 1 cycle after the detected edge.
REQ-026 owner SHALL update on the same cycle the shifter loads.

Reset
REQ-027 Reset SHALL force: shifter to 0xFF, state IDLE, famicom_data 1, owner 7, lock cleared, kb_pending 0, hold count 0, and edge registers 0.
REQ-028 A reset asserted mid-shift SHALL abort the transfer, and a latch edge already high at release SHALL be detected.

Structure
REQ-029 A package joypad_pkg SHALL hold the shifter state enum (IDLE, SHIFT, DONE), the owner codes (PAD0-PAD3=0-3, KBD=4, NONE=7), and the shift width constant 8.
REQ-030 The shift register and its counter SHALL be one sub-module, famicom_shifter; the arbitration and keyboard hold logic stay in the top level.

Verification
REQ-031 Bench: joystick_2=0x05, others 0, latch then 8 pulses -> famicom_data sequence 0,1,0,1,1,1,1,1, owner=2.
REQ-032 Bench: pad1=0x01 locked, then pad0=0x80 also pressed, next latch -> owner stays 1; pad1 released, next latch -> owner 0.
REQ-033 Bench: kb_strobe with kb_code=0x41, KB_HOLD=2, pad0 held -> two latches present keyboard data 0,1,1,1,1,1,0,1; third latch -> owner 0, kb_pending 0.
REQ-034 Bench: latch after 3 of 8 pulses -> shifter reloads, and the full new byte follows from bit0.
REQ-035 Bench: latch and pulse edges on the same cycle -> bit0 of the new byte is presented, with no shift.
REQ-036 Bench: reset after 4 pulses -> famicom_data=1, owner=7; 12 pulses with no latch -> data stays 1.
